// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu command sequencer: opcodes, flag bit
// positions, default datapath latency and result classification.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int unsigned FLG_NAN  = 2;
  localparam int unsigned FLG_INF  = 1;
  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_W    = 3;

  localparam int unsigned FPU_LAT_DFLT = 1;

  // {nan, inf, zero} classification of an IEEE-754 single word
  function automatic logic [FLG_W-1:0] fp_classify(input logic [31:0] word);
    logic [7:0]       expo;
    logic [22:0]      man;
    logic [FLG_W-1:0] flags;
    expo            = word[30:23];
    man             = word[22:0];
    flags           = '0;
    flags[FLG_NAN]  = (expo == 8'hFF) && (man != 23'd0);
    flags[FLG_INF]  = (expo == 8'hFF) && (man == 23'd0);
    flags[FLG_ZERO] = (expo == 8'h00) && (man == 23'd0);
    return flags;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO: synchronous reset, registered pointers, non-fall-through.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (caller guarantees space)
//   pop             remove head; ignored when empty
//   valid           FIFO not empty
//   head            head entry, forced to 0 when empty
//   count           number of stored entries (0..DEPTH)
module fpu_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign valid  = (cnt != '0);
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;
  assign count  = cnt;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only entries behind a valid count are ever read
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_data;
  end

  // Credit flow control upstream must make overflow impossible
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !do_pop && (cnt == CW'(DEPTH))));
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Command front-end and result collector around a fixed-latency fpu.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (credit based)
//   cmd_a, cmd_b, cmd_op, cmd_tag     command payload
//   fpu_a, fpu_b, fpu_opcode          registered operands to the fpu
//   fpu_o                             fpu result, FPU_LAT stages after sampling
//   res_valid/res_ready               result handshake
//   res_data, res_tag, res_flags      FIFO head (0 when res_valid is low)
//   idle                              nothing in flight and FIFO empty
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FPU_LAT = FPU_LAT_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [2:0]       res_flags,
  output logic             idle
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(FPU_LAT + 2);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PL = FPU_LAT + 1;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [FLG_W-1:0] flags;
  } res_t;

  logic             accept;
  logic             capture;
  logic [PL-1:0]    pipe_vld;
  logic [TAG_W-1:0] pipe_tag [PL];
  logic [IW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic [OW-1:0]    occ;
  res_t             push_word;
  res_t             head_word;

  // Every accepted command holds a credit until its result is popped
  assign occ       = OW'(inflight) + OW'(fifo_count);
  assign cmd_ready = !rst && (occ < OW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = pipe_vld[PL-1];
  assign idle      = (occ == '0) && !rst;

  // Operand registers feeding the fpu
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= '0;
    end else if (accept) begin
      fpu_a      <= cmd_a;
      fpu_b      <= cmd_b;
      fpu_opcode <= cmd_op;
    end
  end

  // Valid/tag shift pipe: one stage for the operand register plus FPU_LAT
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < PL; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_tag[0] <= cmd_tag;
      for (int i = 1; i < PL; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // In-flight counter: +1 on accept, -1 on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push_word = '{data: fpu_o, tag: pipe_tag[PL-1], flags: fp_classify(fpu_o)};

  fpu_result_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_word),
    .pop       (res_ready),
    .valid     (res_valid),
    .head      (head_word),
    .count     (fifo_count)
  );

  assign res_data  = head_word.data;
  assign res_tag   = head_word.tag;
  assign res_flags = head_word.flags;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ <= OW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer with a table-driven fpu stub (latency 1).
module tb_fpu_sequencer;
  import fpu_pkg::*;

  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       res_flags;
  logic             idle;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t mon_e;

  fpu_sequencer #(.TAG_W(TAG_W), .DEPTH(4), .FPU_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_opcode (fpu_opcode),
    .fpu_o      (fpu_o),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .res_flags  (res_flags),
    .idle       (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fpu stub: hand-computed answers for the vectors used below
  function automatic logic [31:0] fpu_stub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_ADD && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (op == OP_ADD && a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
    if (op == OP_SUB && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (op == OP_DIV && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == OP_MUL && a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
    if (op == OP_MUL && a == 32'h7FC00000 && b == 32'h3F800000) return 32'h7FC00000;
    if (op == OP_MUL && a == 32'h00000000 && b == 32'h40A00000) return 32'h00000000;
    return 32'h12345678;
  endfunction

  always @(posedge clk) fpu_o <= fpu_stub(fpu_a, fpu_b, fpu_opcode);

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pop expected entries whenever the DUT hands over a result
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("res_valid_unexpected", 64'(res_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_data", 64'(res_data), 64'(mon_e.data));
          chk("res_tag", 64'(res_tag), 64'(mon_e.tag));
          chk("res_flags", 64'(res_flags), 64'(mon_e.flags));
          pop_cyc.push_back(cyc);
        end
      end else if (!res_valid) begin
        chk("gated_head", 64'({res_data, res_tag, res_flags}), 64'd0);
      end
    end
  end

  // Present one command, hold until accepted (bounded), record expectation
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [TAG_W-1:0] tag, input logic [31:0] rdata,
                       input logic [2:0] rflags, output int waited);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 30) begin
        chk("issue_timeout", 64'(cmd_ready), 64'd1);
        break;
      end
    end
    if (cmd_ready) exp_q.push_back('{rdata, tag, rflags});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
    chk("idle_in_rst", 64'(idle), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 64'(idle), 64'd1);
    chk("res_valid_after_rst", 64'(res_valid), 64'd0);
    chk("fpu_regs_after_rst", 64'({fpu_a, fpu_b, fpu_opcode}), 64'd0);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // Single ADD: result first visible three cycles after the accept cycle
    @(posedge clk); #1;
    issue(32'h3F800000, 32'h40000000, OP_ADD, 4'd3, 32'h40400000, 3'b000, w);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("latency_res_valid", 64'(res_valid), 64'(k == 3));
      if (k == 1) begin
        chk("fpu_a_loaded", 64'(fpu_a), 64'h3F800000);
        chk("idle_busy", 64'(idle), 64'd0);
      end
    end
    @(negedge clk);
    chk("idle_after_pop", 64'(idle), 64'd1);

    // Back-to-back MULs with the consumer always ready
    pop_cyc.delete();
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      issue(32'h40000000, 32'h40400000, OP_MUL, 4'(t), 32'h40C00000, 3'b000, w);
      chk("b2b_no_stall", 64'(w), 64'd0);
    end
    wait_drain();
    chk("b2b_pop_count", 64'(pop_cyc.size()), 64'd4);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("b2b_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Consumer stalled: credit runs out at four, then a pop frees one
    @(posedge clk); #1 res_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, OP_MUL, 4'd5, 32'h40000000, 3'b000, w);
    chk("fill_no_stall", 64'(w), 64'd0);
    issue(32'h40000000, 32'h40000000, OP_ADD, 4'd6, 32'h40800000, 3'b000, w);
    chk("fill_no_stall", 64'(w), 64'd0);
    issue(32'h40400000, 32'h3F800000, OP_SUB, 4'd7, 32'h40000000, 3'b000, w);
    chk("fill_no_stall", 64'(w), 64'd0);
    issue(32'h40C00000, 32'h40000000, OP_DIV, 4'd8, 32'h40400000, 3'b000, w);
    chk("fill_no_stall", 64'(w), 64'd0);
    cmd_a = 32'h40000000; cmd_b = 32'h40400000; cmd_op = OP_MUL; cmd_tag = 4'd9;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_res_valid", 64'(res_valid), 64'd1);
    chk("pop_cycle_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cmd_ready_after_pop", 64'(cmd_ready), 64'd1);
    if (cmd_ready) exp_q.push_back('{32'h40C00000, 4'd9, 3'b000});
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_drain();

    // Classification flags
    @(posedge clk); #1;
    issue(32'h7FC00000, 32'h3F800000, OP_MUL, 4'd10, 32'h7FC00000, 3'b100, w);
    issue(32'h00000000, 32'h40A00000, OP_MUL, 4'd11, 32'h00000000, 3'b001, w);
    issue(32'h7F800000, 32'h3F800000, OP_ADD, 4'd12, 32'h7F800000, 3'b010, w);
    wait_drain();

    // Reset with two operations in flight discards them
    @(posedge clk); #1;
    issue(32'h3F800000, 32'h40000000, OP_ADD, 4'd13, 32'h40400000, 3'b000, w);
    issue(32'h40000000, 32'h40000000, OP_ADD, 4'd14, 32'h40800000, 3'b000, w);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("cmd_ready_mid_rst", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    chk("flush_idle", 64'(idle), 64'd1);
    chk("flush_fpu_a", 64'(fpu_a), 64'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("flush_no_result", 64'(res_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
- Command front-end and result collector wrapped around the fpu datapath.
- Accepts operations on a valid/ready command port and drives the fpu A/B/opcode inputs from registers.
- Tracks in-flight operations through the fpu's fixed pipeline latency.
- Captures each result with its tag and classification flags into a result FIFO drained by a valid/ready port. Issue is credit-based, so a result is never dropped.

Parameters:
- TAG_W, 4: width of the user tag carried with each command.
- DEPTH, 4: result FIFO entries and total credit. Must be a power of 2 and ≥ FPU_LAT+2 for full throughput.
- FPU_LAT, 1: register stages inside the fpu, counted from its operand-sampling edge to a valid O.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_a  in  32  IEEE-754 single operand A
- cmd_b  in  32  IEEE-754 single operand B
- cmd_op  in  2  00 ADD, 01 SUB, 10 DIV, 11 MUL
- cmd_tag  in  TAG_W  user tag, returned with the result
- fpu_a  out  32  registered operand to fpu A
- fpu_b  out  32  registered operand to fpu B
- fpu_opcode  out  2  registered opcode to fpu
- fpu_o  in  32  fpu result O
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  result word
- res_tag  out  TAG_W  tag of the result
- res_flags  out  3  {nan, inf, zero} classification of res_data
- idle  out  1  no operation in flight and FIFO empty

Behaviour:
- Reset (clk edge with rst=1):
  - fpu_a, fpu_b, fpu_opcode = 0; in-flight pipe cleared; FIFO pointers and count = 0.
  - res_valid = 0. cmd_ready = 0 while rst is high.
  - idle = 1 from the first cycle after rst falls.
  - Reset mid-operation discards all in-flight and queued results. No stale result may appear afterwards.
- Credit:
  - occ = inflight_count + fifo_count, both registered.
  - cmd_ready = !rst && (occ < DEPTH).
  - cmd_ready does not consider a same-cycle res pop; credit freed by a pop is visible the next cycle.
- Accept (edge where cmd_valid && cmd_ready):
  - Register cmd_a/cmd_b/cmd_op into fpu_a/fpu_b/fpu_opcode.
  - Push {valid=1, tag} into a valid/tag shift pipe of length FPU_LAT+1.
  - Without an accept, fpu_* hold their values and a 0 valid bit enters the pipe.
- Capture:
  - When the pipe's last stage is valid, write {fpu_o, tag, flags(fpu_o)} into the FIFO at that edge.
  - Timing: command accepted in cycle c; fpu samples at the end of c+1 (fpu registers at end of c+FPU_LAT); capture at the end of c+FPU_LAT+1.
  - res_valid is high no earlier than cycle c+FPU_LAT+2 (c+3 at default).
- Throughput: one command per cycle sustained while res_ready=1. Results are returned strictly in issue order.
- Flags, computed from the captured word, exp=[30:23], man=[22:0]:
  - nan = exp==8'hFF && man!=0
  - inf = exp==8'hFF && man==0
  - zero = exp==0 && man==0
- Output:
  - Not fall-through. res_data/res_tag/res_flags present the FIFO head and are 0 when res_valid=0.
  - A pop occurs on res_valid && res_ready.
  - Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- Counts:
  - inflight_count +1 on accept, −1 on capture. Both together in the same cycle leave it unchanged.
  - Range 0..FPU_LAT+1. Occupancy can never exceed DEPTH; a FIFO overflow is an assertion failure.
- idle = (occ==0) && !rst.

Decomposition:
- fpu_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_DIV/OP_MUL
  - flag bit indices FLG_NAN=2, FLG_INF=1, FLG_ZERO=0
  - default FPU_LAT
  - function fp_classify(32-bit) returning the 3-bit flags
- One sub-module, fpu_result_fifo: parameterised width and DEPTH, synchronous reset, push/pop, count output, gated head output.

Test Plan:
- ADD 0x3F800000 + 0x40000000, tag 3, accepted in cycle c -> res_valid first high in c+3: res_data 0x40400000, tag 3, flags 000; idle=1 after the pop.
- Four back-to-back MUL commands, tags 0..3, each 0x40000000 × 0x40400000, res_ready=1 -> four 0x40C00000 results on consecutive cycles, tags 0,1,2,3; cmd_ready never drops.
- res_ready=0 with cmd_valid held high -> exactly 4 accepted, then cmd_ready=0; raise res_ready -> 4 results in order; cmd_ready returns the cycle after the first pop.
- MUL 0x7FC00000 × 0x3F800000 -> flags 100; MUL 0x00000000 × 0x40A00000 -> 0x00000000, flags 001; ADD 0x7F800000 + 0x3F800000 -> exp FF, flags 010.
- Two commands in flight, rst high for one cycle -> next cycle res_valid=0, idle=1, fpu_a=0; no result emerges over the following 10 cycles.
- FIFO full at occ=DEPTH, pop and cmd_valid in the same cycle -> no accept that cycle, accept next cycle; count stays consistent and tags stay in order.
